// File: rtl/bfd_rx_parser.sv
// Parses Ethernet/IPv4/UDP on the MAC RX byte stream and extracts single-hop BFD control fields.
// Optional destination MAC filtering is enabled with `define BFD_RX_MAC_FILTER_EN.
module bfd_rx_parser #(
  parameter logic [15:0] BFD_UDP_PORT = 16'd3784,
  parameter logic [47:0] LOCAL_MAC    = 48'h0,
  parameter int          CNT_W        = 16
) (
  input  logic             rx_mac_aclk,
  input  logic             rx_axi_rstn,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tuser,
  output logic             bfd_valid,
  output logic [31:0]      bfd_src_ip,
  output logic [4:0]       bfd_diag,
  output logic [1:0]       bfd_sta,
  output logic [5:0]       bfd_flags,
  output logic [7:0]       bfd_detect_mult,
  output logic [31:0]      bfd_my_discr,
  output logic [31:0]      bfd_your_discr,
  output logic [31:0]      bfd_des_min_tx,
  output logic [31:0]      bfd_req_min_rx,
  output logic [31:0]      bfd_req_echo_rx,
  output logic [CNT_W-1:0] rx_good_cnt,
  output logic [CNT_W-1:0] rx_drop_cnt
);

  typedef enum logic [2:0] {SYNC, IDLE, HDR, PAD, DROP, DONE} state_t;

  state_t      state, state_nxt;
  logic [6:0]  cnt, cnt_nxt;
  logic        accept, reject, byte_fail;
  logic [31:0] sh_src_ip, sh_my, sh_your, sh_tx, sh_rx, sh_echo, echo_final;
  logic [4:0]  sh_diag;
  logic [1:0]  sh_sta;
  logic [5:0]  sh_flags;
  logic [7:0]  sh_mult;

`ifdef BFD_RX_MAC_FILTER_EN
  // Running match of the destination MAC against both the station address and broadcast.
  logic       mac_loc, mac_bc, mac_loc_nxt, mac_bc_nxt;
  logic [7:0] mac_exp;

  always_comb begin
    mac_exp = 8'h00;
    case (cnt)
      7'd0:    mac_exp = LOCAL_MAC[47:40];
      7'd1:    mac_exp = LOCAL_MAC[39:32];
      7'd2:    mac_exp = LOCAL_MAC[31:24];
      7'd3:    mac_exp = LOCAL_MAC[23:16];
      7'd4:    mac_exp = LOCAL_MAC[15:8];
      7'd5:    mac_exp = LOCAL_MAC[7:0];
      default: mac_exp = 8'h00;
    endcase
    mac_loc_nxt = ((cnt == 7'd0) ? 1'b1 : mac_loc) && (s_axis_tdata == mac_exp);
    mac_bc_nxt  = ((cnt == 7'd0) ? 1'b1 : mac_bc) && (s_axis_tdata == 8'hFF);
  end

  always_ff @(posedge rx_mac_aclk or negedge rx_axi_rstn) begin
    if (!rx_axi_rstn) begin
      mac_loc <= 1'b0;
      mac_bc  <= 1'b0;
    end else if (s_axis_tvalid && (state == IDLE || state == HDR) && cnt <= 7'd5) begin
      mac_loc <= mac_loc_nxt;
      mac_bc  <= mac_bc_nxt;
    end
  end
`else
  logic unused_mac;
  assign unused_mac = ^LOCAL_MAC;
`endif

  always_comb begin
    byte_fail = 1'b0;
    case (cnt)
      7'd12:   byte_fail = (s_axis_tdata != 8'h08);
      7'd13:   byte_fail = (s_axis_tdata != 8'h00);
      7'd14:   byte_fail = (s_axis_tdata != 8'h45);
      7'd22:   byte_fail = (s_axis_tdata != 8'hFF);
      7'd23:   byte_fail = (s_axis_tdata != 8'd17);
      7'd36:   byte_fail = (s_axis_tdata != BFD_UDP_PORT[15:8]);
      7'd37:   byte_fail = (s_axis_tdata != BFD_UDP_PORT[7:0]);
      7'd42:   byte_fail = (s_axis_tdata[7:5] != 3'd1);
      7'd44:   byte_fail = (s_axis_tdata == 8'd0);
      7'd45:   byte_fail = (s_axis_tdata < 8'd24);
      7'd49:   byte_fail = ({sh_my[23:0], s_axis_tdata} == 32'd0);
      default: byte_fail = 1'b0;
    endcase
`ifdef BFD_RX_MAC_FILTER_EN
    if (cnt == 7'd5 && !(mac_loc_nxt || mac_bc_nxt))
      byte_fail = 1'b1;
`endif
  end

  // Frame-level FSM; accept/reject are asserted only on the tlast beat.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    case (state)
      SYNC: if (!s_axis_tvalid) state_nxt = IDLE;
      IDLE: if (s_axis_tvalid) begin
        if (s_axis_tlast) begin
          state_nxt = DONE;
          reject    = 1'b1;
        end else begin
          state_nxt = HDR;
        end
      end
      HDR: if (s_axis_tvalid) begin
        if (byte_fail) begin
          state_nxt = s_axis_tlast ? DONE : DROP;
          reject    = s_axis_tlast;
        end else if (s_axis_tlast) begin
          state_nxt = DONE;
          accept    = (cnt == 7'd65) && !s_axis_tuser;
          reject    = !((cnt == 7'd65) && !s_axis_tuser);
        end else if (cnt == 7'd65) begin
          state_nxt = PAD;
        end
      end
      PAD: if (s_axis_tvalid && s_axis_tlast) begin
        state_nxt = DONE;
        accept    = !s_axis_tuser;
        reject    = s_axis_tuser;
      end
      DROP: if (s_axis_tvalid && s_axis_tlast) begin
        state_nxt = DONE;
        reject    = 1'b1;
      end
      // A beat arriving here means the next frame start was missed, so resynchronise.
      DONE:    state_nxt = s_axis_tvalid ? SYNC : IDLE;
      default: state_nxt = SYNC;
    endcase
  end

  always_comb begin
    cnt_nxt = cnt;
    if (state == SYNC || state == DONE)
      cnt_nxt = 7'd0;
    else if (s_axis_tvalid)
      cnt_nxt = s_axis_tlast ? 7'd0 : ((cnt == 7'd127) ? cnt : cnt + 7'd1);
  end

  assign echo_final = (state == HDR && cnt == 7'd65) ? {sh_echo[23:0], s_axis_tdata} : sh_echo;

  always_ff @(posedge rx_mac_aclk or negedge rx_axi_rstn) begin
    if (!rx_axi_rstn) begin
      state <= SYNC;
      cnt   <= 7'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Shadow capture; fields only reach the outputs once the whole frame is accepted.
  always_ff @(posedge rx_mac_aclk or negedge rx_axi_rstn) begin
    if (!rx_axi_rstn) begin
      sh_src_ip <= '0; sh_diag <= '0; sh_sta  <= '0; sh_flags <= '0; sh_mult <= '0;
      sh_my     <= '0; sh_your <= '0; sh_tx   <= '0; sh_rx    <= '0; sh_echo <= '0;
    end else if (s_axis_tvalid && state == HDR) begin
      if (cnt >= 7'd26 && cnt <= 7'd29) sh_src_ip <= {sh_src_ip[23:0], s_axis_tdata};
      if (cnt == 7'd42) sh_diag <= s_axis_tdata[4:0];
      if (cnt == 7'd43) begin
        sh_sta   <= s_axis_tdata[7:6];
        sh_flags <= s_axis_tdata[5:0];
      end
      if (cnt == 7'd44) sh_mult <= s_axis_tdata;
      if (cnt >= 7'd46 && cnt <= 7'd49) sh_my   <= {sh_my[23:0], s_axis_tdata};
      if (cnt >= 7'd50 && cnt <= 7'd53) sh_your <= {sh_your[23:0], s_axis_tdata};
      if (cnt >= 7'd54 && cnt <= 7'd57) sh_tx   <= {sh_tx[23:0], s_axis_tdata};
      if (cnt >= 7'd58 && cnt <= 7'd61) sh_rx   <= {sh_rx[23:0], s_axis_tdata};
      if (cnt >= 7'd62 && cnt <= 7'd65) sh_echo <= {sh_echo[23:0], s_axis_tdata};
    end
  end

  always_ff @(posedge rx_mac_aclk or negedge rx_axi_rstn) begin
    if (!rx_axi_rstn) begin
      bfd_valid       <= 1'b0;
      bfd_src_ip      <= '0; bfd_diag       <= '0; bfd_sta        <= '0;
      bfd_flags       <= '0; bfd_detect_mult <= '0; bfd_my_discr  <= '0;
      bfd_your_discr  <= '0; bfd_des_min_tx <= '0; bfd_req_min_rx <= '0;
      bfd_req_echo_rx <= '0;
      rx_good_cnt     <= '0;
      rx_drop_cnt     <= '0;
    end else begin
      bfd_valid <= accept;
      if (accept) begin
        bfd_src_ip      <= sh_src_ip;
        bfd_diag        <= sh_diag;
        bfd_sta         <= sh_sta;
        bfd_flags       <= sh_flags;
        bfd_detect_mult <= sh_mult;
        bfd_my_discr    <= sh_my;
        bfd_your_discr  <= sh_your;
        bfd_des_min_tx  <= sh_tx;
        bfd_req_min_rx  <= sh_rx;
        bfd_req_echo_rx <= echo_final;
        rx_good_cnt     <= rx_good_cnt + 1'b1;
      end
      if (reject)
        rx_drop_cnt <= rx_drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bfd_rx_parser.sv
// Directed self-checking bench for bfd_rx_parser; builds BFD frames byte by byte.
module tb_bfd_rx_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  tdata = 8'h00;
  logic        tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0;
  logic        bfd_valid;
  logic [31:0] bfd_src_ip, bfd_my_discr, bfd_your_discr, bfd_des_min_tx, bfd_req_min_rx, bfd_req_echo_rx;
  logic [4:0]  bfd_diag;
  logic [1:0]  bfd_sta;
  logic [5:0]  bfd_flags;
  logic [7:0]  bfd_detect_mult;
  logic [15:0] rx_good_cnt, rx_drop_cnt;

  int          checks = 0;
  int          errors = 0;
  int          strobe_cnt = 0;
  logic [7:0]  frm [0:127];
  logic        strobe;

  bfd_rx_parser #(.BFD_UDP_PORT(16'd3784), .LOCAL_MAC(48'h000A35000001), .CNT_W(16)) dut (
    .rx_mac_aclk(clk), .rx_axi_rstn(rst_n),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
    .bfd_valid(bfd_valid), .bfd_src_ip(bfd_src_ip), .bfd_diag(bfd_diag), .bfd_sta(bfd_sta),
    .bfd_flags(bfd_flags), .bfd_detect_mult(bfd_detect_mult), .bfd_my_discr(bfd_my_discr),
    .bfd_your_discr(bfd_your_discr), .bfd_des_min_tx(bfd_des_min_tx),
    .bfd_req_min_rx(bfd_req_min_rx), .bfd_req_echo_rx(bfd_req_echo_rx),
    .rx_good_cnt(rx_good_cnt), .rx_drop_cnt(rx_drop_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bfd_valid === 1'b1) strobe_cnt++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference BFD frame: TTL 255, UDP dst 3784, vers 1, sta 3, mult 3, tx=rx=1000000, echo 50000.
  task automatic buildGood();
    logic [7:0] hdr [0:65];
    hdr = '{8'h00,8'h0A,8'h35,8'h00,8'h00,8'h01, 8'h00,8'h11,8'h22,8'h33,8'h44,8'h55,
            8'h08,8'h00, 8'h45,8'h00,8'h00,8'h34, 8'h00,8'h00,8'h00,8'h00, 8'hFF,8'h11,8'h00,8'h00,
            8'hC0,8'hA8,8'h01,8'h02, 8'hC0,8'hA8,8'h01,8'h01,
            8'hC0,8'h00,8'h0E,8'hC8, 8'h00,8'h20,8'h00,8'h00,
            8'h20,8'hC0,8'h03,8'h18, 8'h11,8'h22,8'h33,8'h44, 8'h55,8'h66,8'h77,8'h88,
            8'h00,8'h0F,8'h42,8'h40, 8'h00,8'h0F,8'h42,8'h40, 8'h00,8'h00,8'hC3,8'h50};
    for (int i = 0; i < 128; i++) frm[i] = (i < 66) ? hdr[i] : 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int len, input int gap, input logic bad, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      tdata = frm[i]; tvalid = 1'b1; tlast = (i == len - 1); tuser = (i == len - 1) ? bad : 1'b0;
      @(posedge clk); #1;
      if (i == len - 1) seen = bfd_valid;
      tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
      if (gap > 0 && i != len - 1) repeat (gap) @(posedge clk);
    end
  endtask

  task automatic checkFields(input string tag, input logic [31:0] my);
    checkOutput({tag, "_src_ip"}, bfd_src_ip, 32'hC0A80102);
    checkOutput({tag, "_diag"}, {27'd0, bfd_diag}, 32'd0);
    checkOutput({tag, "_sta"}, {30'd0, bfd_sta}, 32'd3);
    checkOutput({tag, "_flags"}, {26'd0, bfd_flags}, 32'd0);
    checkOutput({tag, "_mult"}, {24'd0, bfd_detect_mult}, 32'd3);
    checkOutput({tag, "_my"}, bfd_my_discr, my);
    checkOutput({tag, "_your"}, bfd_your_discr, 32'h55667788);
    checkOutput({tag, "_tx"}, bfd_des_min_tx, 32'd1000000);
    checkOutput({tag, "_rx"}, bfd_req_min_rx, 32'd1000000);
    checkOutput({tag, "_echo"}, bfd_req_echo_rx, 32'd50000);
  endtask

  initial begin
    idle(3);
    checkOutput("rst_valid", {31'd0, bfd_valid}, 32'd0);
    checkOutput("rst_my", bfd_my_discr, 32'd0);
    checkOutput("rst_good", {16'd0, rx_good_cnt}, 32'd0);
    checkOutput("rst_drop", {16'd0, rx_drop_cnt}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    idle(3);

    $display("[TB] good 66-byte frame");
    buildGood();
    applyStimulus(66, 0, 1'b0, strobe);
    checkOutput("t1_strobe", {31'd0, strobe}, 32'd1);
    checkFields("t1", 32'h11223344);
    checkOutput("t1_good", {16'd0, rx_good_cnt}, 32'd1);
    checkOutput("t1_drop", {16'd0, rx_drop_cnt}, 32'd0);
    idle(1);
    checkOutput("t1_pulse_end", {31'd0, bfd_valid}, 32'd0);
    idle(2);

    $display("[TB] padded 70-byte frame with gaps");
    applyStimulus(70, 3, 1'b0, strobe);
    checkOutput("t2_strobe", {31'd0, strobe}, 32'd1);
    checkFields("t2", 32'h11223344);
    checkOutput("t2_good", {16'd0, rx_good_cnt}, 32'd2);
    idle(3);

    $display("[TB] TTL, port and tuser rejects");
    buildGood(); frm[22] = 8'hFE; frm[46] = 8'h99;
    applyStimulus(66, 0, 1'b0, strobe);
    checkOutput("t3_ttl_strobe", {31'd0, strobe}, 32'd0);
    idle(3);
    buildGood(); frm[37] = 8'hC9;
    applyStimulus(66, 0, 1'b0, strobe);
    checkOutput("t3_port_strobe", {31'd0, strobe}, 32'd0);
    idle(3);
    buildGood(); frm[46] = 8'hAA; frm[47] = 8'hBB; frm[48] = 8'hCC; frm[49] = 8'hDD;
    applyStimulus(66, 0, 1'b1, strobe);
    checkOutput("t3_tuser_strobe", {31'd0, strobe}, 32'd0);
    checkOutput("t3_drop", {16'd0, rx_drop_cnt}, 32'd3);
    checkOutput("t3_good", {16'd0, rx_good_cnt}, 32'd2);
    checkFields("t3_hold", 32'h11223344);
    idle(3);

    $display("[TB] truncated and ARP frames");
    buildGood();
    applyStimulus(60, 0, 1'b0, strobe);
    checkOutput("t4_trunc_strobe", {31'd0, strobe}, 32'd0);
    idle(3);
    buildGood(); frm[13] = 8'h06;
    applyStimulus(60, 0, 1'b0, strobe);
    checkOutput("t4_arp_strobe", {31'd0, strobe}, 32'd0);
    checkOutput("t4_drop", {16'd0, rx_drop_cnt}, 32'd5);
    idle(3);

    $display("[TB] field boundary rejects");
    buildGood(); frm[46] = 8'h00; frm[47] = 8'h00; frm[48] = 8'h00; frm[49] = 8'h00;
    applyStimulus(66, 0, 1'b0, strobe);
    checkOutput("t4_my0_strobe", {31'd0, strobe}, 32'd0);
    idle(3);
    buildGood(); frm[45] = 8'd23;
    applyStimulus(66, 0, 1'b0, strobe);
    checkOutput("t4_len23_strobe", {31'd0, strobe}, 32'd0);
    idle(3);
    buildGood(); frm[44] = 8'd0;
    applyStimulus(66, 0, 1'b0, strobe);
    checkOutput("t4_mult0_strobe", {31'd0, strobe}, 32'd0);
    idle(3);
    buildGood();
    applyStimulus(65, 0, 1'b0, strobe);
    checkOutput("t4_len65_strobe", {31'd0, strobe}, 32'd0);
    checkOutput("t4_drop_total", {16'd0, rx_drop_cnt}, 32'd9);
    checkOutput("t4_good_total", {16'd0, rx_good_cnt}, 32'd2);
    checkOutput("t4_strobes", strobe_cnt, 32'd2);
    idle(3);

    $display("[TB] reset in the middle of a good frame");
    buildGood();
    for (int i = 0; i < 66; i++) begin
      @(negedge clk);
      if (i == 30) rst_n = 1'b0;
      if (i == 35) rst_n = 1'b1;
      tdata = frm[i]; tvalid = 1'b1; tlast = (i == 65);
      @(posedge clk); #1;
    end
    tvalid = 1'b0; tlast = 1'b0;
    checkOutput("t5_valid", {31'd0, bfd_valid}, 32'd0);
    checkOutput("t5_src_ip", bfd_src_ip, 32'd0);
    checkOutput("t5_my", bfd_my_discr, 32'd0);
    checkOutput("t5_good", {16'd0, rx_good_cnt}, 32'd0);
    checkOutput("t5_drop", {16'd0, rx_drop_cnt}, 32'd0);
    idle(3);
    applyStimulus(66, 0, 1'b0, strobe);
    checkOutput("t5_next_strobe", {31'd0, strobe}, 32'd1);
    checkFields("t5_next", 32'h11223344);
    checkOutput("t5_next_good", {16'd0, rx_good_cnt}, 32'd1);
    checkOutput("t5_next_drop", {16'd0, rx_drop_cnt}, 32'd0);
    idle(3);

`ifdef BFD_RX_MAC_FILTER_EN
    $display("[TB] destination MAC filter");
    buildGood(); frm[5] = 8'h02;
    applyStimulus(66, 0, 1'b0, strobe);
    checkOutput("t6_other_strobe", {31'd0, strobe}, 32'd0);
    checkOutput("t6_other_drop", {16'd0, rx_drop_cnt}, 32'd1);
    idle(3);
    buildGood(); for (int i = 0; i < 6; i++) frm[i] = 8'hFF;
    applyStimulus(66, 0, 1'b0, strobe);
    checkOutput("t6_bcast_strobe", {31'd0, strobe}, 32'd1);
    checkOutput("t6_bcast_good", {16'd0, rx_good_cnt}, 32'd2);
    idle(3);
    checkOutput("final_strobes", strobe_cnt, 32'd4);
`else
    checkOutput("final_strobes", strobe_cnt, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
